// File: rtl/wb_pwm_ctrl.sv
// wb_pwm_ctrl: Wishbone B4 pipelined slave with the shared PWM timebase and per-channel shadow duty registers.
// Define WB_PWM_CTRL_SYNC_EN to defer channel commits to the counter wrap (glitch-free mode).
module wb_pwm_ctrl #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 4,
  parameter int PRE_BITS = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [5:0]               wb_adr_i,
  input  logic [7:0]               wb_dat_i,
  output logic [7:0]               wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_stall_o,
  output logic [BITS-1:0]          pwm_counter,
  output logic [CHANNELS-1:0]      ch_stb_o,
  output logic [CHANNELS*BITS-1:0] ch_dat_o
);

  logic                          accept_s;
  logic                          write_s;
  logic                          tick_s;
  logic                          enable_r;
  logic [PRE_BITS-1:0]           prescale_r;
  logic [PRE_BITS-1:0]           pre_cnt_r;
  logic [CHANNELS-1:0][BITS-1:0] shadow_r;
  logic [CHANNELS-1:0]           pending_r;
  logic [7:0]                    rd_chan_s;
  logic [7:0]                    rd_data_s;

  assign accept_s   = wb_cyc_i & wb_stb_i;
  assign write_s    = accept_s & wb_we_i;
  assign tick_s     = enable_r & (pre_cnt_r == prescale_r);
  assign wb_stall_o = 1'b0;
  assign ch_dat_o   = shadow_r;

`ifdef WB_PWM_CTRL_SYNC_EN
  logic wrap_s;
  assign wrap_s   = tick_s & (pwm_counter == {BITS{1'b1}});
  // While disabled the counter never wraps, so commits pass straight through.
  assign ch_stb_o = pending_r & {CHANNELS{wrap_s | ~enable_r}};
`else
  assign ch_stb_o = pending_r;
`endif

  // Read mux: zero-extended field of the addressed register, 0 for unmapped addresses.
  always_comb begin
    rd_chan_s = 8'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      rd_chan_s = rd_chan_s | ((wb_adr_i == 6'(i + 2)) ? 8'(shadow_r[i]) : 8'd0);
    end
    case (wb_adr_i)
      6'd0:    rd_data_s = {7'd0, enable_r};
      6'd1:    rd_data_s = 8'(prescale_r);
      default: rd_data_s = rd_chan_s;
    endcase
  end

  // Bus response and control/prescale registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 8'd0;
      enable_r   <= 1'b0;
      prescale_r <= '0;
    end else begin
      wb_ack_o <= accept_s;
      if (accept_s) begin
        wb_dat_o <= rd_data_s;
      end
      if (write_s && (wb_adr_i == 6'd0)) begin
        enable_r <= wb_dat_i[0];
      end
      if (write_s && (wb_adr_i == 6'd1)) begin
        prescale_r <= wb_dat_i[PRE_BITS-1:0];
      end
    end
  end

  // Timebase: prescaler plus free-running counter, both held at 0 while disabled.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pre_cnt_r   <= '0;
      pwm_counter <= '0;
    end else if (!enable_r) begin
      pre_cnt_r   <= '0;
      pwm_counter <= '0;
    end else if (tick_s) begin
      pre_cnt_r   <= '0;
      pwm_counter <= pwm_counter + BITS'(1);
    end else begin
      pre_cnt_r   <= pre_cnt_r + PRE_BITS'(1);
    end
  end

  // Shadow duty registers; a write in the strobe cycle keeps the channel pending.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shadow_r  <= '0;
      pending_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (write_s && (wb_adr_i == 6'(i + 2))) begin
          shadow_r[i]  <= wb_dat_i[BITS-1:0];
          pending_r[i] <= 1'b1;
        end else if (ch_stb_o[i]) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// tb_wb_pwm_ctrl: randomized self-checking bench for wb_pwm_ctrl against a cycle-level reference model.
module tb_wb_pwm_ctrl;
  localparam int CH = 4;
  localparam int B  = 4;
  localparam int PB = 4;
  localparam int W  = 1 + 8 + 1 + B + CH + CH * B;
`ifdef WB_PWM_CTRL_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         cyc   = 1'b0;
  logic         stb   = 1'b0;
  logic         we    = 1'b0;
  logic [5:0]   adr   = 6'd0;
  logic [7:0]   dat_i = 8'd0;
  logic [7:0]   wb_dat_o;
  logic         wb_ack_o;
  logic         wb_stall_o;
  logic [B-1:0] pwm_counter;
  logic [CH-1:0] ch_stb_o;
  logic [CH*B-1:0] ch_dat_o;

  int vectors     = 0;
  int miscompares = 0;

  wb_pwm_ctrl #(.CHANNELS(CH), .BITS(B), .PRE_BITS(PB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_stall_o(wb_stall_o), .pwm_counter(pwm_counter), .ch_stb_o(ch_stb_o), .ch_dat_o(ch_dat_o)
  );

  always #5 clk = ~clk;

  wire [W-1:0] obs = {wb_ack_o, wb_dat_o, wb_stall_o, pwm_counter, ch_stb_o, ch_dat_o};

  // Reference model state
  logic          m_en   = 1'b0;
  int            m_pre  = 0;
  int            m_pcnt = 0;
  int            m_cnt  = 0;
  int            m_sh[CH];
  logic [CH-1:0] m_pend = '0;
  logic          m_ack  = 1'b0;
  logic [7:0]    m_dat  = 8'h00;

  // Channel-1 commit log taken from the DUT outputs
  int  q1_val[$];
  int  q1_cnt[$];
  time q1_t[$];

  function automatic logic [CH-1:0] m_stb();
    logic [CH-1:0] s;
    for (int i = 0; i < CH; i++)
      s[i] = m_pend[i] & (!SYNC || !m_en || (m_pcnt == m_pre && m_cnt == (1 << B) - 1));
    return s;
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    if (a == 0) return {7'd0, m_en};
    if (a == 1) return 8'(m_pre);
    if (a >= 2 && a < 2 + CH) return 8'(m_sh[a-2]);
    return 8'h00;
  endfunction

  function automatic logic [W-1:0] exp_vec();
    logic [CH*B-1:0] d;
    for (int i = 0; i < CH; i++) d[i*B +: B] = B'(m_sh[i]);
    return {m_ack, m_dat, 1'b0, B'(m_cnt), m_stb(), d};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en <= 1'b0; m_pre <= 0; m_pcnt <= 0; m_cnt <= 0;
      m_pend <= '0; m_ack <= 1'b0; m_dat <= 8'h00;
      for (int i = 0; i < CH; i++) m_sh[i] <= 0;
    end else begin
      m_ack <= cyc & stb;
      if (cyc & stb) m_dat <= m_rd(int'(adr));
      m_pend <= m_pend & ~m_stb();
      if (!m_en) begin
        m_pcnt <= 0; m_cnt <= 0;
      end else if (m_pcnt == m_pre) begin
        m_pcnt <= 0; m_cnt <= (m_cnt + 1) % (1 << B);
      end else begin
        m_pcnt <= (m_pcnt + 1) % (1 << PB);
      end
      if (cyc & stb & we) begin
        if (adr == 6'd0) m_en <= dat_i[0];
        else if (adr == 6'd1) m_pre <= int'(dat_i) % (1 << PB);
        else if (int'(adr) < 2 + CH) begin
          m_sh[int'(adr)-2]   <= int'(dat_i) % (1 << B);
          m_pend[int'(adr)-2] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ch_stb_o[1] === 1'b1) begin
      q1_val.push_back(int'(ch_dat_o[2*B-1:B]));
      q1_cnt.push_back(int'(pwm_counter));
      q1_t.push_back($time);
    end
  end

  task automatic set_req(input logic w, input int a, input int d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 6'(a); dat_i = 8'(d);
  endtask

  task automatic set_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 6'd0; dat_i = 8'd0;
  endtask

  task automatic test_reset();
    set_idle();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_async got=%h want=0", obs); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL reset_idle got=%h want=%h", obs, exp_vec()); end
    end
  endtask

  task automatic test_timebase();
    int pres[6];
    int runs[6];
    pres = '{0, 2, 0, 0, 12, 3};
    runs = '{40, 50, 40, 40, 8, 30};
    pres[2] = $urandom_range(0, 15);
    pres[3] = $urandom_range(0, 7);
    @(negedge clk); set_req(1'b1, 1, 0);
    @(negedge clk); set_req(1'b1, 0, 1);
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k <= runs[p]; k++) begin
        @(negedge clk); vectors++;
        if (obs !== exp_vec()) begin miscompares++; $display("FAIL timebase pre=%0d got=%h want=%h", pres[p], obs, exp_vec()); end
        if (k == 0) set_req(1'b1, 1, pres[p]); else set_idle();
      end
    end
  endtask

  task automatic test_sync_commit();
    bit found = 1'b0;
    bit collided = 1'b0;
    logic [CH-1:0] s;
    q1_val.delete(); q1_cnt.delete(); q1_t.delete();
    @(negedge clk); set_req(1'b1, 1, 0);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL commit_wait got=%h want=%h", obs, exp_vec()); end
      set_idle();
      if (m_cnt == 5 && m_pre == 0) begin found = 1'b1; set_req(1'b1, 3, 9); end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL commit_wait timeout got=%0d want=5", m_cnt); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL sync_commit got=%h want=%h", obs, exp_vec()); end
      set_idle();
      s = m_stb();
      if (!collided && s[1]) begin collided = 1'b1; set_req(1'b1, 3, 3); end
    end
    #1;
    vectors++;
    if (q1_val.size() != 2) begin
      miscompares++; $display("FAIL commit_count got=%0d want=2", q1_val.size());
    end else begin
      vectors++;
      if (q1_val[0] != 9 || q1_val[1] != 3) begin
        miscompares++; $display("FAIL commit_values got=%0d,%0d want=9,3", q1_val[0], q1_val[1]);
      end
      vectors++;
      if (q1_cnt[0] != (SYNC ? 15 : 6)) begin
        miscompares++; $display("FAIL commit_position got=%0d want=%0d", q1_cnt[0], SYNC ? 15 : 6);
      end
      vectors++;
      if (q1_t[1] - q1_t[0] != (SYNC ? 160 : 10)) begin
        miscompares++; $display("FAIL collision_gap got=%0t want=%0d", q1_t[1] - q1_t[0], SYNC ? 160 : 10);
      end
    end
  endtask

  task automatic test_readback();
    bit op_c[6];
    bit op_w[6];
    int op_a[6];
    int op_d[6];
    int op_e[6];
    op_c = '{1, 1, 1, 1, 1, 0};
    op_w = '{1, 0, 0, 1, 0, 0};
    op_a = '{3, 3, 40, 1, 1, 0};
    op_d = '{9, 0, 0, 255, 0, 0};
    op_e = '{-1, 9, 0, -1, 15, -1};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL readback got=%h want=%h", obs, exp_vec()); end
      if (i > 0 && op_e[i-1] >= 0) begin
        vectors++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'(op_e[i-1])) begin
          miscompares++;
          $display("FAIL read_adr%0d got ack=%b dat=%h want ack=1 dat=%h", op_a[i-1], wb_ack_o, wb_dat_o, 8'(op_e[i-1]));
        end
      end
      if (i < 6 && op_c[i]) set_req(op_w[i], op_a[i], op_d[i]); else set_idle();
    end
  endtask

  task automatic test_disabled();
    int v;
    bit found = 1'b0;
    v = $urandom_range(1, 15);
    @(negedge clk); set_req(1'b1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL disable got=%h want=%h", obs, exp_vec()); end
      if (k == 3) set_req(1'b1, 2, v); else set_idle();
    end
    @(negedge clk); set_idle(); vectors++;
    if (ch_stb_o[0] !== 1'b1 || pwm_counter !== '0 || ch_dat_o[B-1:0] !== B'(v)) begin
      miscompares++; $display("FAIL disabled_load got stb=%b cnt=%0d dat=%0d want stb=1 cnt=0 dat=%0d", ch_stb_o[0], pwm_counter, ch_dat_o[B-1:0], v);
    end
    @(negedge clk); vectors++;
    if (ch_stb_o[0] !== 1'b0) begin miscompares++; $display("FAIL disabled_pulse got=%b want=0", ch_stb_o[0]); end
    set_req(1'b1, 1, 0);
    @(negedge clk); set_req(1'b1, 0, 1);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL enabled_wait got=%h want=%h", obs, exp_vec()); end
      set_idle();
      if (m_en && m_cnt == 5) begin found = 1'b1; set_req(1'b1, 2, v ^ 5); end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL enabled_wait timeout got=%0d want=5", m_cnt); end
    @(negedge clk); set_idle(); vectors++;
    if (obs !== exp_vec()) begin miscompares++; $display("FAIL enabled_write got=%h want=%h", obs, exp_vec()); end
`ifndef WB_PWM_CTRL_SYNC_EN
    vectors++;
    if (ch_stb_o[0] !== 1'b1 || ch_dat_o[B-1:0] !== B'(v ^ 5)) begin
      miscompares++; $display("FAIL immediate_load got stb=%b dat=%0d want stb=1 dat=%0d", ch_stb_o[0], ch_dat_o[B-1:0], v ^ 5);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int r;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", k, obs, exp_vec()); end
      r = $urandom_range(0, 9);
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 2) != 0);
      we  = $urandom_range(0, 1);
      adr = (r < 8) ? 6'(r) : ((r == 8) ? 6'd40 : 6'd63);
      dat_i = 8'($urandom_range(0, 255));
    end
    @(negedge clk); set_idle();
  endtask

  task automatic test_reset_midrun();
    bit found = 1'b0;
    set_req(1'b1, 1, 0);
    @(negedge clk); set_req(1'b1, 0, 1);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL midrun_wait got=%h want=%h", obs, exp_vec()); end
      set_idle();
      if (m_en && m_cnt == 6) begin found = 1'b1; set_req(1'b1, 2, 7); end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL midrun_wait timeout got=%0d want=6", m_cnt); end
    @(posedge clk); #2;
    set_idle();
    rst = 1'b1;
    #1; vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_midrun got=%h want=0", obs); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); vectors++;
      if (wb_ack_o !== 1'b0 || ch_stb_o !== '0 || obs !== exp_vec()) begin
        miscompares++; $display("FAIL after_reset got=%h want=%h", obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_timebase();
    test_sync_commit();
    test_readback();
    test_disabled();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
